// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file write arbiter.
package regfile_arb_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int BURST_CNT_W = 4;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] rot_s;
    logic                 found_s;
    int                   sum_s;

    assign rot_s = {valid, valid} >> ptr;

    // Scan the rotated vector so position k maps back to requester (ptr + k) mod NUM_REQ.
    always_comb begin
        found_s = 1'b0;
        idx     = '0;
        sum_s   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && rot_s[k]) begin
                found_s = 1'b1;
                sum_s   = int'(ptr) + k;
                if (sum_s >= NUM_REQ) begin
                    sum_s = sum_s - NUM_REQ;
                end else begin
                    sum_s = sum_s;
                end
                idx = IDX_W'(sum_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant derived from the chosen index.
    always_comb begin
        if (found_s) begin
            grant = NUM_REQ'(1) << idx;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter with locked bursts in front of a register file.
// Optional macro REGFILE_WRITE_ARBITER_FWD_EN adds write-to-read forwarding.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 1,
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                          locked,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [DATA_W-1:0]             rf_rd_data,
    output logic [DATA_W-1:0]             rd_data
);

    localparam int IW = idx_width(NUM_REQ);

    arb_state_e             state_r;
    logic [IW-1:0]          ptr_r;
    logic [IW-1:0]          owner_r;
    logic [BURST_CNT_W-1:0] burst_cnt_r;

    logic [NUM_REQ-1:0]     pick_grant_s;
    logic [IW-1:0]          pick_idx_s;
    logic [IW-1:0]          acc_idx_s;
    logic                   accept_s;
    logic [ADDR_W-1:0]      sel_addr_s;
    logic [DATA_W-1:0]      sel_data_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_picker (
        .valid (req_valid),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s)
    );

    // Ready: picker result in ARB, only the owner in LOCKED, nothing while in reset.
    always_comb begin
        req_ready = '0;
        acc_idx_s = pick_idx_s;
        if (rst) begin
            req_ready = '0;
        end else if (state_r == LOCKED) begin
            req_ready[owner_r] = req_valid[owner_r];
            acc_idx_s          = owner_r;
        end else begin
            req_ready = pick_grant_s;
        end
    end

    assign accept_s = |(req_valid & req_ready);

    // Select the accepted requester's address and data.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_idx_s == IW'(i)) begin
                sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
                sel_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // Arbitration FSM and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ARB;
            ptr_r       <= '0;
            owner_r     <= '0;
            burst_cnt_r <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            grant_id    <= '0;
        end else begin
            rf_we <= accept_s;
            if (accept_s) begin
                rf_waddr <= sel_addr_s;
                rf_wdata <= sel_data_s;
                grant_id <= acc_idx_s;
            end else begin
                rf_waddr <= rf_waddr;
            end
            case (state_r)
                ARB: begin
                    if (accept_s) begin
                        ptr_r <= (pick_idx_s == IW'(NUM_REQ - 1)) ? '0 : pick_idx_s + IW'(1);
                        if (req_lock[pick_idx_s] && (MAX_BURST > 1)) begin
                            state_r     <= LOCKED;
                            owner_r     <= pick_idx_s;
                            burst_cnt_r <= BURST_CNT_W'(1);
                        end else begin
                            state_r <= ARB;
                        end
                    end else begin
                        state_r <= ARB;
                    end
                end
                LOCKED: begin
                    // Owner dropping valid releases the lock with no write this cycle.
                    if (!req_valid[owner_r]) begin
                        state_r     <= ARB;
                        burst_cnt_r <= '0;
                    end else if (req_lock[owner_r] &&
                                 (burst_cnt_r + BURST_CNT_W'(1) != BURST_CNT_W'(MAX_BURST))) begin
                        burst_cnt_r <= burst_cnt_r + BURST_CNT_W'(1);
                    end else begin
                        state_r     <= ARB;
                        burst_cnt_r <= '0;
                    end
                end
                default: begin
                    state_r     <= ARB;
                    burst_cnt_r <= '0;
                end
            endcase
        end
    end

    assign locked = (state_r == LOCKED);

`ifdef REGFILE_WRITE_ARBITER_FWD_EN
    // Bypass the write landing this cycle to a reader of the same register.
    always_comb begin
        if (rf_we && (rf_waddr == rd_addr)) begin
            rd_data = rf_wdata;
        end else begin
            rd_data = rf_rd_data;
        end
    end
`else
    logic unused_rd_addr_s;
    assign unused_rd_addr_s = ^rd_addr;
    assign rd_data          = rf_rd_data;
`endif

endmodule
